// File: rtl/lzw_pkg.sv
// Shared types and helpers for the LZW dictionary search block.
// Holds the FSM state enum, the header-field layout and the words-per-length helper.
package lzw_pkg;

  // Header word layout: the string length sits in the low bits, everything above is zero.
  localparam int unsigned HdrLenLsb = 0;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StCmp,
    StSkip,
    StInsHdr,
    StInsData,
    StDone
  } lzw_state_e;

  // Number of data words that follow a header for a string of len chars.
  function automatic int unsigned nw(input int unsigned len, input int unsigned cpw);
    return (len + cpw - 1) / cpw;
  endfunction

endpackage

// File: rtl/lzw_dict_search_if.sv
// Bundle of the controller-side search handshake and the dictionary RAM bus.
// master: LZW controller plus RAM model side; slave: lzw_dict_search.
// Optional probe_count signal exists only when LZW_SEARCH_STATS_EN is defined.
interface lzw_dict_search_if #(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned RAM_W     = 16,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned CODE_W    = 12,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
);
  logic              dict_init;
  logic [ADDR_W-1:0] dict_base;
  logic [ADDR_W-1:0] dict_limit;
  logic              str_clear;
  logic              str_push;
  logic [CHAR_W-1:0] str_char;
  logic [LEN_W-1:0]  str_len;
  logic              str_full;
  logic              search_valid;
  logic              insert_on_miss;
  logic              search_ready;
  logic              result_valid;
  logic              result_found;
  logic [CODE_W-1:0] result_code;
  logic              dict_full;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic [RAM_W-1:0]  ram_rdata;
  logic              ram_wr_en;
  logic [RAM_W-1:0]  ram_wdata;
`ifdef LZW_SEARCH_STATS_EN
  logic [ADDR_W-1:0] probe_count;

  modport master (
    output dict_init, dict_base, dict_limit, str_clear, str_push, str_char,
    output search_valid, insert_on_miss, ram_rdata,
    input  str_len, str_full, search_ready, result_valid, result_found, result_code,
    input  dict_full, ram_addr, ram_rd_en, ram_wr_en, ram_wdata, probe_count
  );
  modport slave (
    input  dict_init, dict_base, dict_limit, str_clear, str_push, str_char,
    input  search_valid, insert_on_miss, ram_rdata,
    output str_len, str_full, search_ready, result_valid, result_found, result_code,
    output dict_full, ram_addr, ram_rd_en, ram_wr_en, ram_wdata, probe_count
  );
`else
  modport master (
    output dict_init, dict_base, dict_limit, str_clear, str_push, str_char,
    output search_valid, insert_on_miss, ram_rdata,
    input  str_len, str_full, search_ready, result_valid, result_found, result_code,
    input  dict_full, ram_addr, ram_rd_en, ram_wr_en, ram_wdata
  );
  modport slave (
    input  dict_init, dict_base, dict_limit, str_clear, str_push, str_char,
    input  search_valid, insert_on_miss, ram_rdata,
    output str_len, str_full, search_ready, result_valid, result_found, result_code,
    output dict_full, ram_addr, ram_rd_en, ram_wr_en, ram_wdata
  );
`endif
endinterface

// File: rtl/lzw_string_pack.sv
// Candidate-string register plus char-to-word packing.
// Ports: clk/rst_n; accept gates clear/push (only honoured while the search FSM is idle);
// len/full report the length; char0 is the first symbol; word is dictionary word word_idx
// of the packed string (char i in word i/CPW at bit (i%CPW)*CHAR_W, unused slots zero).
module lzw_string_pack #(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned RAM_W     = 16,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic              clr,
  input  logic              push,
  input  logic [CHAR_W-1:0] chr,
  output logic [LEN_W-1:0]  len,
  output logic              full,
  output logic [CHAR_W-1:0] char0,
  input  logic [LEN_W-1:0]  word_idx,
  output logic [RAM_W-1:0]  word
);
  localparam int unsigned CPW   = RAM_W / CHAR_W;
  localparam int unsigned NWMax = (MAX_CHARS + CPW - 1) / CPW;
  localparam int unsigned FlatW = NWMax * RAM_W;

  logic [MAX_CHARS-1:0][CHAR_W-1:0] chars_q, chars_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [FlatW-1:0]                 flat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chars_q <= '0;
      len_q   <= '0;
    end else begin
      chars_q <= chars_d;
      len_q   <= len_d;
    end
  end

  // Clearing zeroes every slot so padding in the last word is always 0.
  always_comb begin
    chars_d = chars_q;
    len_d   = len_q;
    if (accept) begin
      if (clr) begin
        chars_d = '0;
        len_d   = '0;
      end
      if (push && (clr || !full)) begin
        for (int i = 0; i < int'(MAX_CHARS); i++) begin
          if (int'(len_d) == i) chars_d[i] = chr;
        end
        len_d = len_d + LEN_W'(1);
      end
    end
  end

  assign len   = len_q;
  assign full  = (len_q == LEN_W'(MAX_CHARS));
  assign char0 = chars_q[0];
  assign flat  = FlatW'(chars_q);

  always_comb begin
    word = '0;
    for (int k = 0; k < int'(NWMax); k++) begin
      if (int'(word_idx) == k) word = flat[k*RAM_W +: RAM_W];
    end
  end

endmodule

// File: rtl/lzw_dict_search.sv
// LZW dictionary search: walks the packed dictionary from dict_base to the insert pointer,
// returns the matching code, or appends the candidate string on a miss when asked to.
// Ports: Clk, Rst_n (async, active low); bus (lzw_dict_search_if.slave) carrying the
// dictionary control, string ops, search handshake, result and single-port RAM bus.
// Optional: define LZW_SEARCH_STATS_EN to add probe_count (headers read in last search).
module lzw_dict_search
  import lzw_pkg::*;
#(
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned MAX_CHARS = 16,
  parameter int unsigned RAM_W     = 16,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned CODE_W    = 12,
  parameter int unsigned LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input logic             Clk,
  input logic             Rst_n,
  lzw_dict_search_if.slave bus
);
  localparam int unsigned       CPW       = RAM_W / CHAR_W;
  localparam logic [CODE_W-1:0] FirstCode = CODE_W'(2 ** CHAR_W);

  lzw_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CODE_W-1:0] cur_code_q, cur_code_d;
  logic [ADDR_W-1:0] insert_ptr_q, insert_ptr_d;
  logic [CODE_W-1:0] next_code_q, next_code_d;
  logic              dict_full_q, dict_full_d;
  logic [LEN_W-1:0]  nw_q, nw_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic              data_q, data_d;
  logic              insert_q, insert_d;
  logic              found_q, found_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic [LEN_W-1:0]  str_len;
  logic [CHAR_W-1:0] str_char0;
  logic [RAM_W-1:0]  str_word;
  logic              str_accept;
  logic [LEN_W-1:0]  hdr_len;
  logic [LEN_W-1:0]  ins_nw;
  logic [ADDR_W-1:0] ins_end;
  logic              miss;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en, ram_wr_en, result_valid;
  logic [RAM_W-1:0]  ram_wdata;

  assign str_accept = (state_q == StIdle);

  lzw_string_pack #(
    .CHAR_W    (CHAR_W),
    .MAX_CHARS (MAX_CHARS),
    .RAM_W     (RAM_W),
    .LEN_W     (LEN_W)
  ) u_pack (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .accept   (str_accept),
    .clr      (bus.str_clear),
    .push     (bus.str_push),
    .chr      (bus.str_char),
    .len      (str_len),
    .full     (bus.str_full),
    .char0    (str_char0),
    .word_idx (k_q),
    .word     (str_word)
  );

  assign hdr_len = bus.ram_rdata[HdrLenLsb +: LEN_W];
  assign ins_nw  = LEN_W'(nw(32'(str_len), CPW));
  assign ins_end = insert_ptr_q + ADDR_W'(ins_nw);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cur_code_q   <= '0;
      insert_ptr_q <= '0;
      next_code_q  <= FirstCode;
      dict_full_q  <= 1'b0;
      nw_q         <= '0;
      k_q          <= '0;
      data_q       <= 1'b0;
      insert_q     <= 1'b0;
      found_q      <= 1'b0;
      code_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cur_code_q   <= cur_code_d;
      insert_ptr_q <= insert_ptr_d;
      next_code_q  <= next_code_d;
      dict_full_q  <= dict_full_d;
      nw_q         <= nw_d;
      k_q          <= k_d;
      data_q       <= data_d;
      insert_q     <= insert_d;
      found_q      <= found_d;
      code_q       <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cur_code_d   = cur_code_q;
    insert_ptr_d = insert_ptr_q;
    next_code_d  = next_code_q;
    dict_full_d  = dict_full_q;
    nw_d         = nw_q;
    k_d          = k_q;
    data_d       = data_q;
    insert_d     = insert_q;
    found_d      = found_q;
    code_d       = code_q;
    miss         = 1'b0;
    ram_addr     = '0;
    ram_rd_en    = 1'b0;
    ram_wr_en    = 1'b0;
    ram_wdata    = '0;
    result_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.search_valid) begin
          insert_d = bus.insert_on_miss;
          if (str_len == '0) begin
            found_d = 1'b0;
            code_d  = '0;
            state_d = StDone;
          end else if (str_len == LEN_W'(1)) begin
            // Single symbols are implicit codes and never stored.
            found_d = 1'b1;
            code_d  = CODE_W'(str_char0);
            state_d = StDone;
          end else begin
            addr_d     = bus.dict_base;
            cur_code_d = FirstCode;
            state_d    = StHdr;
          end
        end
      end
      StHdr: begin
        if (addr_q == insert_ptr_q) begin
          miss = 1'b1;
        end else begin
          ram_rd_en = 1'b1;
          ram_addr  = addr_q;
          data_d    = 1'b0;
          state_d   = StCmp;
        end
      end
      StCmp: begin
        if (!data_q) begin
          // Header word arrives; a matching length starts the pipelined data reads.
          nw_d = LEN_W'(nw(32'(hdr_len), CPW));
          if (hdr_len == '0 || hdr_len > LEN_W'(MAX_CHARS)) begin
            miss = 1'b1;
          end else if (hdr_len != str_len) begin
            state_d = StSkip;
          end else begin
            ram_rd_en = 1'b1;
            ram_addr  = addr_q + ADDR_W'(1);
            k_d       = '0;
            data_d    = 1'b1;
          end
        end else if (bus.ram_rdata != str_word) begin
          state_d = StSkip;
        end else if (k_q == nw_q - LEN_W'(1)) begin
          found_d = 1'b1;
          code_d  = cur_code_q;
          state_d = StDone;
        end else begin
          ram_rd_en = 1'b1;
          ram_addr  = addr_q + ADDR_W'(2) + ADDR_W'(k_q);
          k_d       = k_q + LEN_W'(1);
        end
      end
      StSkip: begin
        addr_d     = addr_q + ADDR_W'(1) + ADDR_W'(nw_q);
        cur_code_d = cur_code_q + CODE_W'(1);
        state_d    = StHdr;
      end
      StInsHdr: begin
        ram_wr_en = 1'b1;
        ram_addr  = insert_ptr_q;
        ram_wdata = RAM_W'(str_len) << HdrLenLsb;
        k_d       = '0;
        state_d   = StInsData;
      end
      StInsData: begin
        ram_wr_en = 1'b1;
        ram_addr  = insert_ptr_q + ADDR_W'(1) + ADDR_W'(k_q);
        ram_wdata = str_word;
        if (k_q == nw_q - LEN_W'(1)) begin
          // Pointer moves only once the whole entry is written.
          insert_ptr_d = insert_ptr_q + ADDR_W'(1) + ADDR_W'(nw_q);
          found_d      = 1'b0;
          code_d       = next_code_q;
          next_code_d  = next_code_q + CODE_W'(1);
          state_d      = StDone;
        end else begin
          k_d = k_q + LEN_W'(1);
        end
      end
      StDone: begin
        result_valid = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (miss) begin
      found_d = 1'b0;
      state_d = StDone;
      if (!insert_q) begin
        code_d = '0;
      end else if (ins_end > bus.dict_limit || next_code_q == '1) begin
        dict_full_d = 1'b1;
        code_d      = '1;
      end else begin
        nw_d    = ins_nw;
        state_d = StInsHdr;
      end
    end

    // Init aborts whatever is in flight, including this cycle's strobes and result.
    if (bus.dict_init) begin
      state_d      = StIdle;
      insert_ptr_d = bus.dict_base;
      next_code_d  = FirstCode;
      dict_full_d  = 1'b0;
      ram_rd_en    = 1'b0;
      ram_wr_en    = 1'b0;
      result_valid = 1'b0;
    end
  end

`ifdef LZW_SEARCH_STATS_EN
  logic [ADDR_W-1:0] probe_q, probe_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) probe_q <= '0;
    else        probe_q <= probe_d;
  end

  always_comb begin
    probe_d = probe_q;
    if (state_q == StIdle && bus.search_valid && !bus.dict_init) begin
      probe_d = '0;
    end else if (state_q == StHdr && ram_rd_en) begin
      probe_d = probe_q + ADDR_W'(1);
    end
  end

  assign bus.probe_count = probe_q;
`endif

  assign bus.str_len      = str_len;
  assign bus.search_ready = (state_q == StIdle);
  assign bus.result_valid = result_valid;
  assign bus.result_found = found_q;
  assign bus.result_code  = code_q;
  assign bus.dict_full    = dict_full_q;
  assign bus.ram_addr     = ram_addr;
  assign bus.ram_rd_en    = ram_rd_en;
  assign bus.ram_wr_en    = ram_wr_en;
  assign bus.ram_wdata    = ram_wdata;

endmodule

// File: tb/tb_lzw_dict_search.sv
// Scoreboard bench for lzw_dict_search: stimulus pushes expected results, a negedge
// monitor pops and compares on every result_valid. Includes a small RAM model.
module tb_lzw_dict_search;
  localparam int unsigned CHAR_W = 8, MAX_CHARS = 16, RAM_W = 16, ADDR_W = 18, CODE_W = 12;

  typedef struct {
    logic              found;
    logic [CODE_W-1:0] code;
    int                issue;
    int                lat;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  lzw_dict_search_if #(
    .CHAR_W (CHAR_W), .MAX_CHARS (MAX_CHARS), .RAM_W (RAM_W), .ADDR_W (ADDR_W), .CODE_W (CODE_W)
  ) bus ();

  lzw_dict_search #(
    .CHAR_W (CHAR_W), .MAX_CHARS (MAX_CHARS), .RAM_W (RAM_W), .ADDR_W (ADDR_W), .CODE_W (CODE_W)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [0:1023];
  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, rd101_cnt = 0, n_res = 0;
  int n_cmp = 0, n_bad = 0;
  exp_t exp_q[$];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (bus.ram_wr_en) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
    if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr[9:0]];
  end

  // Monitor: strobe accounting and scoreboard pop.
  always @(negedge Clk) begin
    exp_t e;
    if (bus.ram_rd_en) rd_cnt++;
    if (bus.ram_wr_en) wr_cnt++;
    if (bus.ram_rd_en && bus.ram_addr == 18'h101) rd101_cnt++;
    if (bus.ram_rd_en && bus.ram_wr_en) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_wr_overlap: both strobes high at cycle %0d", cyc);
    end
    if (Rst_n && bus.result_valid) begin
      n_res++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: found=%0b code=0x%0h with nothing pending",
                 bus.result_found, bus.result_code);
      end else begin
        e = exp_q.pop_front();
        if (bus.result_found !== e.found || bus.result_code !== e.code) begin
          n_bad++;
          $display("FAIL result: got found=%0b code=0x%0h, expected found=%0b code=0x%0h",
                   bus.result_found, bus.result_code, e.found, e.code);
        end
        if (e.lat >= 0) begin
          n_cmp++;
          if (cyc - e.issue != e.lat) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected %0d", cyc - e.issue, e.lat);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_init(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] limit);
    bus.dict_base  = base;
    bus.dict_limit = limit;
    bus.dict_init  = 1'b1;
    cycle();
    bus.dict_init  = 1'b0;
  endtask

  // Load n chars from s, first char in s[7:0]; clear is merged with the first push.
  task automatic load(input logic [31:0] s, input int n);
    if (n == 0) begin
      bus.str_clear = 1'b1;
      cycle();
    end
    for (int i = 0; i < n; i++) begin
      bus.str_clear = (i == 0);
      bus.str_push  = 1'b1;
      bus.str_char  = s[i*8 +: 8];
      cycle();
    end
    bus.str_clear = 1'b0;
    bus.str_push  = 1'b0;
  endtask

  task automatic search(input logic ins, input logic f, input logic [CODE_W-1:0] code,
                        input int lat);
    exp_t e;
    int   n0;
    e.found = f; e.code = code; e.issue = cyc; e.lat = lat;
    exp_q.push_back(e);
    n0 = n_res;
    bus.search_valid   = 1'b1;
    bus.insert_on_miss = ins;
    cycle();
    bus.search_valid   = 1'b0;
    bus.insert_on_miss = 1'b0;
    for (int i = 0; i < 300 && n_res == n0; i++) cycle();
    if (n_res == n0) begin
      n_cmp++; n_bad++;
      $display("FAIL search_timeout: no result_valid within 300 cycles");
      exp_q.delete();
    end
  endtask

  initial begin
    int r0, w0;
    logic hit;
    bus.dict_init = 0; bus.dict_base = '0; bus.dict_limit = '0;
    bus.str_clear = 0; bus.str_push = 0; bus.str_char = '0;
    bus.search_valid = 0; bus.insert_on_miss = 0;
    repeat (2) cycle();
    check("rst_result_valid", 32'(bus.result_valid), 0);
    check("rst_rd_wr", {bus.ram_rd_en, bus.ram_wr_en}, 0);
    check("rst_str_len", 32'(bus.str_len), 0);
    Rst_n = 1'b1;
    cycle();

    // 1: single symbol is its own code, one-cycle latency, no RAM.
    do_init(18'h100, 18'h3FF);
    load(32'h41, 1);
    check("len_one", 32'(bus.str_len), 1);
    r0 = rd_cnt;
    search(1'b0, 1'b1, 12'h041, 1);
    check("single_no_reads", rd_cnt - r0, 0);

    // Empty string: found=0, code=0, no RAM.
    load(32'h0, 0);
    r0 = rd_cnt;
    search(1'b1, 1'b0, 12'h000, 1);
    check("empty_no_reads", rd_cnt - r0, 0);

    // 2: insert "AB" into empty dict.
    load(32'h4241, 2);
    r0 = rd_cnt; w0 = wr_cnt;
    search(1'b1, 1'b0, 12'h100, -1);
    check("ab_writes", wr_cnt - w0, 2);
    check("ab_reads", rd_cnt - r0, 0);
    check("ab_hdr", 32'(mem[10'h100]), 32'h0002);
    check("ab_data", 32'(mem[10'h101]), 32'h4241);

    // 3: "AB" found.
    search(1'b0, 1'b1, 12'h100, -1);

    // 4: "ABC" lands at 0x102, then found skipping "AB" data.
    load(32'h434241, 3);
    search(1'b1, 1'b0, 12'h101, -1);
    check("abc_hdr", 32'(mem[10'h102]), 32'h0003);
    check("abc_d0", 32'(mem[10'h103]), 32'h4241);
    check("abc_d1", 32'(mem[10'h104]), 32'h0043);
    r0 = rd_cnt; w0 = rd101_cnt;
    search(1'b0, 1'b1, 12'h101, -1);
    check("abc_reads", rd_cnt - r0, 4);
    check("abc_skip_data", rd101_cnt - w0, 0);

    // Miss without insert.
    load(32'h5958, 2);
    search(1'b0, 1'b0, 12'h000, -1);

    // 5: limit too low -> refused.
    bus.dict_limit = 18'h102;
    load(32'h5A5958, 3);
    w0 = wr_cnt;
    search(1'b1, 1'b0, 12'hFFF, -1);
    check("full_flag", 32'(bus.dict_full), 1);
    check("full_no_writes", wr_cnt - w0, 0);

    // String register saturation.
    for (int i = 0; i < 17; i++) begin
      bus.str_clear = (i == 0);
      bus.str_push  = 1'b1;
      bus.str_char  = 8'h61 + 8'(i);
      cycle();
    end
    bus.str_clear = 1'b0; bus.str_push = 1'b0;
    check("str_full", 32'(bus.str_full), 1);
    check("str_len_sat", 32'(bus.str_len), 16);

    // 6: reset during INS_DATA.
    bus.dict_limit = 18'h3FF;
    load(32'h525150, 3);
    bus.search_valid = 1'b1; bus.insert_on_miss = 1'b1;
    cycle();
    bus.search_valid = 1'b0; bus.insert_on_miss = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (bus.ram_wr_en && bus.ram_addr == 18'h106) hit = 1'b1;
      else cycle();
    end
    check("ins_data_reached", 32'(hit), 1);
    Rst_n = 1'b0;
    #1;
    check("wr_drop", 32'(bus.ram_wr_en), 0);
    repeat (2) cycle();
    Rst_n = 1'b1;
    cycle();
    check("post_rst_outs", {bus.result_valid, bus.result_found, bus.dict_full,
                            bus.ram_rd_en, bus.ram_wr_en}, 0);
    check("post_rst_code", 32'(bus.result_code), 0);
    check("post_rst_len", 32'(bus.str_len), 0);
    // insert_ptr=0 and next_code=FIRST_CODE: a fresh insert from base 0 lands at 0.
    bus.dict_base = '0;
    load(32'h4241, 2);
    search(1'b1, 1'b0, 12'h100, -1);
    check("rst_ptr_hdr", 32'(mem[10'h000]), 32'h0002);
    check("rst_ptr_data", 32'(mem[10'h001]), 32'h4241);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lzw_dict_search.md
Name: lzw_dict_search

Overview:
Parametrised successor to the LZW datapath register file. It holds the current candidate string and walks the packed dictionary RAM from its base to the insert pointer, comparing entries with an internal FSM. It returns the matching code, or appends the string as a new entry on a miss. It sits between the LZW top controller and the single-port dictionary RAM, and replaces the controller-driven String/StringRAM/JumpAddress micro-ops with one search handshake.

Parameters:
CHAR_W, 8, bits per symbol
MAX_CHARS, 16, maximum string length in symbols
RAM_W, 16, dictionary word width; must be a multiple of CHAR_W (CPW = RAM_W/CHAR_W chars per word)
ADDR_W, 18, dictionary address width
CODE_W, 12, output code width; FIRST_CODE = 2**CHAR_W
LEN_W, $clog2(MAX_CHARS+1), string length field width

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
dict_init  in  1  pulse: insert_ptr<=dict_base, next_code<=FIRST_CODE, dict_full<=0
dict_base  in  ADDR_W  first dictionary word address
dict_limit  in  ADDR_W  last writable dictionary address (inclusive)
str_clear  in  1  empty the string register
str_push  in  1  append str_char
str_char  in  CHAR_W  symbol to append
str_len  out  LEN_W  current string length
str_full  out  1  str_len == MAX_CHARS
search_valid  in  1  request a search of the current string
insert_on_miss  in  1  sampled with search_valid: append the string on a miss
search_ready  out  1  high only in IDLE
result_valid  out  1  one-cycle pulse, no backpressure
result_found  out  1  match found
result_code  out  CODE_W  matched code, or new code on a miss with insert
dict_full  out  1  sticky: last insert was refused
ram_addr  out  ADDR_W  RAM address
ram_rd_en  out  1  read strobe; ram_rdata is valid the next cycle
ram_rdata  in  RAM_W  read data
ram_wr_en  out  1  write strobe
ram_wdata  out  RAM_W  write data

Behaviour:
- Reset:
  - All outputs 0; string empty.
  - insert_ptr = 0; next_code = FIRST_CODE; FSM = IDLE.
  - A reset mid-search or mid-insert drops ram_wr_en at once; a partial entry is not committed (insert_ptr is unchanged).
- Entry format at address A:
  - Header word: bits [LEN_W-1:0] = L, remaining bits 0.
  - Followed by NW(L) = ceil(L/CPW) data words.
  - Char i sits in word i/CPW at bit offset (i%CPW)*CHAR_W; unused slots are 0.
  - The k-th entry from dict_base has code FIRST_CODE+k.
- String register:
  - Ops are accepted only in IDLE and ignored otherwise.
  - str_clear and str_push in the same cycle gives length 1 holding str_char.
  - str_push while str_full is ignored.
- FSM: IDLE -> HDR -> CMP -> (SKIP -> HDR) | DONE; a miss with insert goes INS_HDR -> INS_DATA -> DONE; DONE -> IDLE.
  - IDLE, search_valid=1, str_len=0: result_valid next cycle, found=0, code=0, no RAM access.
  - IDLE, search_valid=1, str_len=1: result_valid next cycle, found=1, code=zero-extended char, no RAM access.
  - Otherwise: addr=dict_base, cur_code=FIRST_CODE, go to HDR.
  - HDR: if addr == insert_ptr, the walk ends as a miss. Otherwise read the header.
  - A header with L=0 or L>MAX_CHARS is treated as end of dictionary (miss).
  - L != str_len: jump = addr+1+NW(L), cur_code++, no data reads.
  - L == str_len: read NW(L) words, one per cycle, pipelined. On the first mismatching word, stop and jump as above.
  - If every word matches: found=1, code=cur_code.
  - Address and code arithmetic is unsigned modulo 2**ADDR_W and 2**CODE_W.
- Miss with insert_on_miss=1:
  - Refused if insert_ptr+NW(str_len) > dict_limit or next_code == 2**CODE_W-1. Then dict_full<=1, result found=0, code = all ones, no writes.
  - Otherwise write the header, then NW data words, at insert_ptr onward, one per cycle.
  - Then insert_ptr += 1+NW, result code = next_code, next_code++.
- A miss with insert_on_miss=0 gives found=0, code=0.
- result_valid pulses in DONE.
- dict_init while busy aborts the operation, with no result pulse and no further writes.
- ram_rd_en and ram_wr_en are never asserted together.

Optional Feature:
LZW_SEARCH_STATS_EN:
- Defined: adds output probe_count[ADDR_W-1:0], the number of headers read in the last search. It is zeroed when a search is accepted and held after result_valid.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Decomposition:
- Package lzw_pkg: FSM state enum, the NW() words-per-length function, and the header-field layout constants.
- One natural sub-module, lzw_string_pack: the string register plus char-to-word packing, exposing word k for comparison and writing.

Test Plan:
1. dict_init base=0x100, push 'A' (0x41), search -> result_valid after 1 cycle, found=1, code=0x041, ram_rd_en never asserted.
2. Empty dict, push "AB", search with insert -> writes 0x100=0x0002 and 0x101=0x4241; found=0, code=0x100; insert_ptr=0x102.
3. Same "AB" searched again -> found=1, code=0x100.
4. "ABC" inserted after "AB" -> code=0x101; "ABC" search skips the "AB" entry without reading its data.
5. dict_limit=0x102, then insert "XYZ" -> dict_full=1, code=0xFFF, ram_wr_en never asserted.
6. Rst_n low during INS_DATA -> ram_wr_en low within the same cycle; after reset insert_ptr=0, all outputs 0.
